// File: rtl/timer_sched_pkg.sv
// Shared definitions for the timer scheduler: FSM encoding, ID width helpers
// and a one-hot decoder used to steer the done pulse.
package timer_sched_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_LOAD  = 2'd1;
    localparam logic [1:0] ST_COUNT = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    typedef enum logic [1:0] {
        IDLE  = ST_IDLE,
        LOAD  = ST_LOAD,
        COUNT = ST_COUNT,
        DONE  = ST_DONE
    } state_t;

    localparam int MAX_REQ  = 8;
    localparam int MAX_ID_W = $clog2(MAX_REQ);

    function automatic int id_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic logic [MAX_REQ-1:0] idx_to_onehot(input logic [MAX_ID_W-1:0] idx);
        logic [MAX_REQ-1:0] oh;
        oh      = '0;
        oh[idx] = 1'b1;
        return oh;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: the search for a requesting channel
// starts at rr_ptr and wraps; a pointer held at zero gives lowest-index priority.
module rr_arbiter
    import timer_sched_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int ID_W  = id_width(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [ID_W-1:0]  rr_ptr,
    output logic [ID_W-1:0]  winner,
    output logic             valid
);

    logic [2*N_REQ-1:0] dbl_req;
    logic [N_REQ-1:0]   rot_req;
    logic [ID_W:0]      sum;

    // Rotating a doubled copy puts channel rr_ptr at bit 0, so the first set
    // bit of rot_req is the round-robin winner relative to the pointer.
    always_comb begin
        dbl_req = {req, req} >> rr_ptr;
        rot_req = dbl_req[N_REQ-1:0];
        winner  = '0;
        valid   = 1'b0;
        sum     = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (!valid && rot_req[i]) begin
                sum = {1'b0, rr_ptr} + (ID_W+1)'(i);
                if (sum >= (ID_W+1)'(N_REQ)) begin
                    sum = sum - (ID_W+1)'(N_REQ);
                end
                winner = sum[ID_W-1:0];
                valid  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/timer_sched.sv
// Shared down-counting delay engine for N_REQ requesters with a one-cycle done pulse.
// Define TIMER_SCHED_PRIO_EN for fixed lowest-index priority instead of round-robin.
module timer_sched
    import timer_sched_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int CNT_W = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [N_REQ-1:0]         req,
    input  logic [N_REQ*CNT_W-1:0]   dly,
    output logic                     busy,
    output logic [$clog2(N_REQ)-1:0] grant_id,
    output logic [N_REQ-1:0]         done
);

    localparam int ID_W = id_width(N_REQ);

    state_t           state;
    state_t           next_state;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_d;
    logic [CNT_W-1:0] dly_cur;
    logic [CNT_W-1:0] dly_arr [N_REQ];
    logic [ID_W-1:0]  rr_ptr;
    logic [ID_W-1:0]  rr_d;
    logic [ID_W-1:0]  grant_d;
    logic [ID_W-1:0]  win_id;
    logic [ID_W-1:0]  ptr_after;
    logic             win_valid;
    logic             req_cur;
    logic             busy_d;
    logic [N_REQ-1:0] done_d;

    for (genvar g = 0; g < N_REQ; g++) begin : g_dly
        assign dly_arr[g] = dly[g*CNT_W +: CNT_W];
    end

    assign req_cur   = req[grant_id];
    assign dly_cur   = dly_arr[grant_id];
    assign ptr_after = (grant_id == ID_W'(N_REQ-1)) ? '0 : grant_id + 1'b1;

    rr_arbiter #(
        .N_REQ (N_REQ),
        .ID_W  (ID_W)
    ) u_arb (
        .req    (req),
        .rr_ptr (rr_ptr),
        .winner (win_id),
        .valid  (win_valid)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Dropping the owning request in LOAD or COUNT abandons the count with no done.
    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (win_valid) begin
                    next_state = LOAD;
                end
            end
            LOAD: begin
                next_state = req_cur ? COUNT : IDLE;
            end
            COUNT: begin
                if (!req_cur) begin
                    next_state = IDLE;
                end else if (cnt == CNT_W'(1)) begin
                    next_state = DONE;
                end
            end
            DONE: begin
                next_state = IDLE;
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // A zero delay is loaded as one so that dly=0 and dly=1 finish on the same edge.
    always_comb begin
        cnt_d   = cnt;
        grant_d = grant_id;
        rr_d    = rr_ptr;
        done_d  = '0;
        busy_d  = (next_state != IDLE);
        case (state)
            IDLE: begin
                if (win_valid) begin
                    grant_d = win_id;
                end
            end
            LOAD: begin
                if (!req_cur) begin
                    rr_d = ptr_after;
                end else if (dly_cur == '0) begin
                    cnt_d = CNT_W'(1);
                end else begin
                    cnt_d = dly_cur;
                end
            end
            COUNT: begin
                if (!req_cur) begin
                    rr_d = ptr_after;
                end else if (cnt > CNT_W'(1)) begin
                    cnt_d = cnt - 1'b1;
                end
            end
            DONE: begin
                rr_d = ptr_after;
            end
            default: begin
            end
        endcase
        if (next_state == DONE) begin
            done_d = N_REQ'(idx_to_onehot(MAX_ID_W'(grant_id)));
        end
`ifdef TIMER_SCHED_PRIO_EN
        rr_d = '0;
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt      <= '0;
            rr_ptr   <= '0;
            grant_id <= '0;
            busy     <= 1'b0;
            done     <= '0;
        end else begin
            cnt      <= cnt_d;
            rr_ptr   <= rr_d;
            grant_id <= grant_d;
            busy     <= busy_d;
            done     <= done_d;
        end
    end

endmodule

// File: tb/tb_timer_sched.sv
// Scoreboard bench for timer_sched: a transaction-level reference model predicts
// grants, busy and done pulses; a negedge monitor compares against the DUT.
module tb_timer_sched;

    localparam int N = 4;
    localparam int W = 16;

    logic           clk = 1'b0;
    logic           rst = 1'b0;
    logic [N-1:0]   req = '0;
    logic [N*W-1:0] dly = '0;
    logic           busy;
    logic [1:0]     grant_id;
    logic [N-1:0]   done;

    timer_sched #(
        .N_REQ (N),
        .CNT_W (W)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .req      (req),
        .dly      (dly),
        .busy     (busy),
        .grant_id (grant_id),
        .done     (done)
    );

    always #5 clk = ~clk;

    typedef struct {
        int ch;
        int e;
    } exp_t;

    exp_t sb[$];
    exp_t item;
    int   vectors     = 0;
    int   miscompares = 0;
    int   edge_n      = 0;
    bit   m_active    = 1'b0;
    int   m_owner     = 0;
    int   m_grant     = 0;
    int   m_done_e    = 0;
    int   m_ptr       = 0;
    int   m_gid       = 0;
    logic m_busy      = 1'b0;
    bit   auto_drop   = 1'b1;

    function automatic int next_ptr(input int ch);
`ifdef TIMER_SCHED_PRIO_EN
        return 0;
`else
        return (ch + 1) % N;
`endif
    endfunction

    function automatic int pick(input logic [N-1:0] r, input int start);
        for (int k = 0; k < N; k++) begin
            if (r[(start + k) % N]) return (start + k) % N;
        end
        return -1;
    endfunction

    function automatic int chan_dly(input logic [N*W-1:0] d, input int ch);
        return int'(d[ch*W +: W]);
    endfunction

    // Reference model: one job at a time; done lands max(D,1) edges after the
    // LOAD edge, and dropping the owner's request before then cancels the job.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_active = 1'b0;
            m_ptr    = 0;
            m_busy   = 1'b0;
            m_gid    = 0;
        end else begin
            edge_n++;
            if (m_active) begin
                if (edge_n > m_grant && edge_n <= m_done_e && !req[m_owner]) begin
                    m_active = 1'b0;
                    m_busy   = 1'b0;
                    m_ptr    = next_ptr(m_owner);
                end else if (edge_n == m_grant + 1) begin
                    int d;
                    d        = chan_dly(dly, m_owner);
                    m_done_e = edge_n + ((d == 0) ? 1 : d);
                end else if (edge_n == m_done_e) begin
                    sb.push_back('{ch: m_owner, e: edge_n});
                end else if (edge_n == m_done_e + 1) begin
                    m_active = 1'b0;
                    m_busy   = 1'b0;
                    m_ptr    = next_ptr(m_owner);
                end
            end else if (req != '0) begin
                m_owner  = pick(req, m_ptr);
                m_active = 1'b1;
                m_grant  = edge_n;
                m_done_e = 32'h7fff_ffff;
                m_busy   = 1'b1;
                m_gid    = m_owner;
            end
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] expv);
        vectors++;
        if (act !== expv) begin
            miscompares++;
            $display("[TB] FAIL %s at edge %0d: got %0h, expected %0h", name, edge_n, act, expv);
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            checkOutput("busy", 32'(busy), 32'(m_busy));
            checkOutput("grant_id", 32'(grant_id), 32'(m_gid));
            if (sb.size() > 0 && sb[0].e <= edge_n) begin
                item = sb.pop_front();
                checkOutput("done", 32'(done), 32'(1) << item.ch);
            end else begin
                checkOutput("done_quiet", 32'(done), 32'd0);
            end
        end
    end

    task automatic applyStimulus(input int cycles);
        for (int c = 0; c < cycles; c++) begin
            @(posedge clk);
            #1;
            if (auto_drop) req = req & ~done;
        end
    endtask

    task automatic setDly(input int ch, input int val);
        dly[ch*W +: W] = W'(val);
    endtask

    initial begin
        #2 rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        applyStimulus(2);

        // single request, delay 5
        setDly(2, 5);
        req[2] = 1'b1;
        applyStimulus(12);

        // reset in the middle of a long count
        setDly(0, 100);
        req[0] = 1'b1;
        applyStimulus(42);
        rst = 1'b1;
        req = '0;
        applyStimulus(2);
        rst = 1'b0;
        applyStimulus(3);

        // all four channels at once, each releasing on its own done
        for (int ch = 0; ch < N; ch++) setDly(ch, 3);
        req = 4'b1111;
        applyStimulus(30);

        // zero, one and maximum delays
        setDly(1, 0);
        req[1] = 1'b1;
        applyStimulus(6);
        setDly(1, 1);
        req[1] = 1'b1;
        applyStimulus(6);
        setDly(1, 16'hFFFF);
        req[1] = 1'b1;
        applyStimulus(65545);

        // abort of ch3 at cnt=2 with ch1 waiting
        rst = 1'b1;
        applyStimulus(1);
        rst = 1'b0;
        applyStimulus(1);
        setDly(3, 6);
        req[3] = 1'b1;
        applyStimulus(1);
        setDly(1, 4);
        req[1] = 1'b1;
        applyStimulus(5);
        req[3] = 1'b0;
        applyStimulus(15);

        // delay changed while counting must not affect the running job
        setDly(0, 10);
        req[0] = 1'b1;
        applyStimulus(4);
        setDly(0, 2);
        applyStimulus(15);

        // randomized traffic with occasional aborts and delay changes
        for (int c = 0; c < 2500; c++) begin
            applyStimulus(1);
            for (int ch = 0; ch < N; ch++) begin
                if (!req[ch]) begin
                    if ($urandom_range(7) == 0) begin
                        setDly(ch, int'($urandom_range(12)));
                        req[ch] = 1'b1;
                    end
                end else if ($urandom_range(63) == 0) begin
                    req[ch] = 1'b0;
                end
                if ($urandom_range(31) == 0) setDly(ch, int'($urandom_range(12)));
            end
        end

        req = '0;
        applyStimulus(6);
        checkOutput("scoreboard_drained", 32'(sb.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
